// File: rtl/ram_seq_ctrl.sv
// Block-transfer sequencer for a small register-file RAM. LOAD streams a
// valid/ready source into consecutive addresses; DUMP streams consecutive words to a sink.
module ram_seq_ctrl #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic          abort,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DUMP,
    S_DONE
  } state_e;

  // A len of zero means the whole memory, so the word counter needs one extra bit.
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_LEFT   = {{AW{1'b0}}, 1'b1};

  state_e          state_q;
  logic [AW-1:0]   ptr_q;
  logic [AW:0]     remain_q;
  logic [DW-1:0]   out_data_q;
  logic            out_valid_q;
  logic            done_q;

  logic            dump_load;
  logic            dump_accept;

  // abort wins over a same-cycle handshake, so the RAM never sees a stray write.
  assign in_ready    = (state_q == S_LOAD) && !abort;
  assign ram_wr      = in_ready && in_valid;
  assign dump_accept = out_valid_q && out_ready;
  assign dump_load   = (!out_valid_q || out_ready) && (remain_q != '0);

  assign ram_addr  = ptr_q;
  assign ram_din   = in_data;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make ordering inside this block significant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remain_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_q    <= base;
            remain_q <= (len == '0) ? FULL_COUNT : {1'b0, len};
            state_q  <= mode ? S_DUMP : S_LOAD;
          end
        end

        S_LOAD: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (ram_wr) begin
            ptr_q    <= ptr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (remain_q == ONE_LEFT) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        S_DUMP: begin
          if (abort) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end else if (dump_load) begin
            out_data_q  <= ram_dout;
            out_valid_q <= 1'b1;
            ptr_q       <= ptr_q + 1'b1;
            remain_q    <= remain_q - 1'b1;
          end else if (dump_accept) begin
            // An accept without a reload only happens once the counter is exhausted.
            out_valid_q <= 1'b0;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Self-checking bench for ram_seq_ctrl: a behavioural RAM on the DUT pins plus a
// reference image of memory and expected word queues derived from the transfer rules.
module tb_ram_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, mode, abort;
  logic [3:0] base, len;
  logic [3:0] in_data;
  logic       in_valid, in_ready;
  logic [3:0] out_data;
  logic       out_valid, out_ready;
  logic       busy, done;
  logic [3:0] ram_addr, ram_din, ram_dout;
  logic       ram_wr;

  int total = 0;
  int bad   = 0;

  logic [3:0] mem     [16];
  logic [3:0] mem_ref [16];

  always #5 clk = ~clk;

  ram_seq_ctrl #(.AW(4), .DW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base), .len(len),
    .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // 16x4 register file: synchronous write, combinational read.
  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic m, input logic [3:0] b, input logic [3:0] l);
    start = 1'b1; mode = m; base = b; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 16; i++) check(tag, mem[i], mem_ref[i]);
  endtask

  // pat: 0 = valid every cycle, 1 = valid toggles 1,0,1..., 2 = random valid.
  // seq: when set, word k carries the value of its own address.
  task automatic do_load(input logic [3:0] b, input logic [3:0] l, input int pat, input bit seq);
    int n, k, cyc;
    logic v, tgl;
    logic [3:0] a;
    n = (l == 0) ? 16 : int'(l);
    k = 0; cyc = 0; tgl = 1'b1;
    start_cmd(1'b0, b, l);
    while (k < n && cyc < 200) begin
      v = (pat == 0) ? 1'b1 : (pat == 1) ? tgl : 1'($urandom_range(0, 1));
      tgl = ~tgl;
      a = 4'((int'(b) + k) % 16);
      in_valid = v;
      in_data  = seq ? a : 4'($urandom_range(0, 15));
      #1;
      check("ld_ready", in_ready, 1);
      check("ld_wr", ram_wr, v);
      check("ld_busy", busy, 1);
      check("ld_done_early", done, 0);
      if (v) begin
        check("ld_addr", ram_addr, a);
        mem_ref[a] = in_data;
        k++;
      end
      cyc++;
      tick();
    end
    in_valid = 1'b0;
    check("ld_count", k, n);
    if (pat == 0) check("ld_cycles", cyc, n);
    check("ld_done", done, 1);
    check("ld_done_busy", busy, 1);
    check("ld_done_wr", ram_wr, 0);
    tick();
    check("ld_done_pulse", done, 0);
    check("ld_idle_busy", busy, 0);
    check("ld_idle_ready", in_ready, 0);
  endtask

  // rmode: 0 = out_ready held high, 1 = low for the first two valid cycles, 2 = random.
  task automatic do_dump(input logic [3:0] b, input logic [3:0] l, input int rmode);
    int n, idx, cyc, lowcnt;
    logic r;
    logic [3:0] exp_q[$];
    n = (l == 0) ? 16 : int'(l);
    exp_q = {};
    for (int k = 0; k < n; k++) exp_q.push_back(mem_ref[(int'(b) + k) % 16]);
    idx = 0; cyc = 0; lowcnt = 0;
    start_cmd(1'b1, b, l);
    while (idx < n && cyc < 300) begin
      check("dp_done_early", done, 0);
      check("dp_wr", ram_wr, 0);
      check("dp_in_ready", in_ready, 0);
      check("dp_busy", busy, 1);
      if (cyc == 0) check("dp_first_lat", out_valid, 0);
      else if (rmode == 0) check("dp_thru", out_valid, 1);
      if (rmode == 0) r = 1'b1;
      else if (rmode == 1) r = (out_valid && lowcnt < 2) ? 1'b0 : 1'b1;
      else r = 1'($urandom_range(0, 1));
      if (rmode == 1 && out_valid && lowcnt < 2) lowcnt++;
      out_ready = r;
      if (out_valid) begin
        check("dp_data", out_data, exp_q[idx]);
        if (r) idx++;
      end
      cyc++;
      tick();
    end
    out_ready = 1'b0;
    check("dp_count", idx, n);
    if (rmode == 0) check("dp_cycles", cyc, n + 1);
    check("dp_done", done, 1);
    check("dp_done_valid", out_valid, 0);
    tick();
    check("dp_done_pulse", done, 0);
    check("dp_idle_busy", busy, 0);
  endtask

  initial begin
    logic [3:0] d;
    rst = 1'b0; start = 1'b0; mode = 1'b0; base = '0; len = '0; abort = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; mem_ref[i] = '0; end
    #12;
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_wr", ram_wr, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    do_load(4'd3, 4'd4, 0, 1'b0);
    check_ram("ram_after_ld1");
    do_load(4'd14, 4'd4, 1, 1'b0);
    check_ram("ram_after_wrap");
    do_load(4'd0, 4'd0, 2, 1'b1);
    check_ram("ram_after_full");

    do_dump(4'd5, 4'd3, 1);
    do_dump(4'd0, 4'd0, 0);

    // Abort during a handshake, with a start attempted mid-transfer first.
    start_cmd(1'b0, 4'd2, 4'd5);
    in_valid = 1'b1; d = 4'($urandom_range(0, 15)); in_data = d;
    #1;
    check("ab_first_wr", ram_wr, 1);
    check("ab_first_addr", ram_addr, 2);
    mem_ref[2] = d;
    tick();
    in_valid = 1'b0; start = 1'b1; mode = 1'b1; base = 4'd9; len = 4'd1;
    tick();
    start = 1'b0;
    check("ab_start_ign_addr", ram_addr, 3);
    check("ab_start_ign_busy", busy, 1);
    in_valid = 1'b1; in_data = ~d; abort = 1'b1;
    #1;
    check("ab_wr", ram_wr, 0);
    check("ab_ready", in_ready, 0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("ab_idle_busy", busy, 0);
    check("ab_no_done", done, 0);
    check("ab_ptr", ram_addr, 3);
    tick();
    check("ab_no_done2", done, 0);
    check_ram("ram_after_abort");

    // Asynchronous reset in the middle of a DUMP with a word pending.
    start_cmd(1'b1, 4'd4, 4'd8);
    out_ready = 1'b0;
    tick();
    check("rd_valid_pre", out_valid, 1);
    check("rd_data_pre", out_data, mem_ref[4]);
    #1 rst = 1'b0;
    #1;
    check("rd_valid", out_valid, 0);
    check("rd_busy", busy, 0);
    check("rd_addr", ram_addr, 0);
    check("rd_done", done, 0);
    check("rd_data", out_data, 0);
    #1 rst = 1'b1;
    tick();
    check("rd_idle", busy, 0);
    check_ram("ram_after_rst");

    do_load(4'd7, 4'd9, 2, 1'b0);
    do_dump(4'd10, 4'd11, 2);
    do_dump(4'd13, 4'd6, 1);
    check_ram("ram_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
Sequencer directly upstream of the 16x4 register-file RAM. It drives the RAM's addr/WR/dataIN pins and reads its combinational dataOUT. It runs block transfers: LOAD streams words from a valid/ready source into consecutive RAM addresses; DUMP streams consecutive RAM words out to a valid/ready sink. Only this block drives the RAM's address and write-enable pins.

Parameters:
AW, 4, RAM address width; depth = 2^AW
DW, 4, RAM data width

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle command strobe, sampled only in IDLE
mode  input  1  0 = LOAD, 1 = DUMP; sampled with start
base  input  AW  first address of the transfer
len  input  AW  word count; 0 encodes 2^AW (full memory)
abort  input  1  cancel the transfer in progress
in_data  input  DW  LOAD source word
in_valid  input  1  LOAD source valid
in_ready  output  1  LOAD handshake ready
out_data  output  DW  DUMP word (registered)
out_valid  output  1  DUMP word valid
out_ready  input  1  DUMP sink ready
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse on normal completion
ram_addr  output  AW  to RAM addr
ram_wr  output  1  to RAM WR
ram_din  output  DW  to RAM dataIN
ram_dout  input  DW  from RAM dataOUT (combinational read of ram_addr)

Behaviour:
- Reset (rst=0, async): state=IDLE; ptr=0, remain=0, out_data=0, out_valid=0, done=0. Outputs in_ready=0, ram_wr=0, ram_addr=0, busy=0. Reset mid-transfer abandons it; the RAM is not written during or after reset.
- States: IDLE, LOAD, DUMP, DONE.
- IDLE:
  - start=1 latches ptr=base and remain=len (0 -> 2^AW, so remain is AW+1 bits).
  - Next state is LOAD when mode=0, DUMP when mode=1.
  - start in any other state is ignored.
- ram_addr=ptr in every state; ram_din=in_data at all times.
- LOAD:
  - in_ready=1. ram_wr = in_valid & in_ready, combinational; the RAM captures the word on the same edge.
  - Each handshake: ptr=ptr+1 mod 2^AW (wraps 15->0), remain=remain-1.
  - The handshake with remain=1 moves to DONE.
  - in_valid=0 stalls with no write and no pointer change.
- DUMP:
  - ram_wr=0, in_ready=0.
  - Output register loads when out_valid=0 or (out_valid & out_ready), and remain>0: out_data<=ram_dout, out_valid<=1, ptr+1 mod 2^AW, remain-1.
  - Sink accepts (out_valid & out_ready) with no reload: out_valid<=0.
  - Move to DONE on the edge where the last word is accepted and remain=0.
  - Timing: start at edge N -> DUMP from N; first out_valid at edge N+1. With out_ready held at 1, throughput is one word per cycle.
  - out_data holds stable while out_valid=1 and out_ready=0.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
- abort=1 in LOAD or DUMP:
  - Next state IDLE, out_valid<=0, no done pulse.
  - abort has priority over a same-cycle handshake: ram_wr is forced to 0 and in_ready=0 that cycle.
  - abort in IDLE or DONE is ignored.
- In IDLE: in_ready=0 and ram_wr=0.

Test Plan:
- LOAD: base=3, len=4, words A,B,C,D on consecutive cycles -> ram_wr high 4 cycles at addr 3,4,5,6; done pulses one cycle later; RAM[3..6]=A..D.
- LOAD wrap: base=14, len=4, in_valid toggling 1,0,1,0,... -> writes only on valid cycles at addr 14,15,0,1; busy held until done.
- DUMP backpressure: RAM[0..15]=0..F, base=5, len=3, out_ready low 2 cycles after the first valid -> out_data 5 held stable, then 6, 7; done after 7 is accepted; ram_wr never asserted.
- len=0 DUMP, base=0, out_ready=1 -> 16 consecutive words 0..F, one per cycle, first out_valid 1 cycle after start, done once.
- abort during a LOAD handshake cycle, and start asserted while busy -> no write on the abort cycle, no done, IDLE next cycle; the mid-transfer start does not change ptr.
- rst driven low mid-DUMP with out_valid=1 -> out_valid, busy and ram_addr go to 0 immediately, without a clock edge; after release, start works normally.
